// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU program loader: widths, opcodes, field helpers,
// loader state encoding and error codes.
package cpu_pkg;

  localparam int INST_W      = 20;
  localparam int DEPTH       = 32;
  localparam int ADDR_W      = 5;
  localparam int RUN_TIMEOUT = 1023;
  localparam int TMO_W       = 10;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MUL  = 2'd2,
    OP_HALT = 2'd3
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_RESET_CPU,
    ST_STREAM,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } ld_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_FORMAT   = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } ld_err_e;

  function automatic logic [1:0] inst_op(input logic [INST_W-1:0] inst);
    return inst[19:18];
  endfunction

  function automatic logic [5:0] inst_src1(input logic [INST_W-1:0] inst);
    return inst[17:12];
  endfunction

  function automatic logic [5:0] inst_src2(input logic [INST_W-1:0] inst);
    return inst[11:6];
  endfunction

  function automatic logic [5:0] inst_dst(input logic [INST_W-1:0] inst);
    return inst[5:0];
  endfunction

endpackage

// File: rtl/prog_buf.sv
// Program buffer: DEPTH x INST_W, one write port and one synchronous read port
// with a single cycle of read latency.
module prog_buf
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [INST_W-1:0] rdata_o
);

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [INST_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_loader.sv
// Host-side program loader: assembles 3-byte instruction frames into a buffer,
// resets the CPU, streams the program into its instruction memory, then supervises the run.
module prog_loader
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              cpu_rst_n,
  output logic              cpu_ld_mode,
  output logic [INST_W-1:0] cpu_inst,
  input  logic              cpu_halted,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W:0]   inst_count
);

  localparam logic [ADDR_W:0]  CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RUN_TIMEOUT - 1);

  ld_state_e         state_q, state_d;
  ld_err_e           err_q, err_d;
  logic [1:0]        phase_q, phase_d;
  logic [15:0]       asm_q, asm_d;
  logic [ADDR_W:0]   inst_cnt_q, inst_cnt_d;
  logic [ADDR_W:0]   strm_q, strm_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              rc_q, rc_d;
  logic              done_q, done_d;

  logic              buf_we;
  logic [ADDR_W-1:0] buf_raddr;
  logic [INST_W-1:0] buf_rdata;

  prog_buf u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (inst_cnt_q[ADDR_W-1:0]),
    .wdata_i ({byte_in[3:0], asm_q}),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      err_q      <= ERR_NONE;
      phase_q    <= '0;
      asm_q      <= '0;
      inst_cnt_q <= '0;
      strm_q     <= '0;
      tmo_q      <= '0;
      rc_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      phase_q    <= phase_d;
      asm_q      <= asm_d;
      inst_cnt_q <= inst_cnt_d;
      strm_q     <= strm_d;
      tmo_q      <= tmo_d;
      rc_q       <= rc_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    phase_d    = phase_q;
    asm_d      = asm_q;
    inst_cnt_d = inst_cnt_q;
    strm_d     = strm_q;
    tmo_d      = tmo_q;
    rc_d       = rc_q;
    done_d     = 1'b0;
    buf_we     = 1'b0;
    // Address 0 outside STREAM so word 0 is already fetched on the first STREAM cycle.
    buf_raddr  = '0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (load_start) begin
          state_d    = ST_RECV;
          err_d      = ERR_NONE;
          inst_cnt_d = '0;
          phase_d    = '0;
        end
      end
      ST_RECV: begin
        if (byte_valid) begin
          unique case (phase_q)
            2'd0: begin
              asm_d[7:0] = byte_in;
              phase_d    = 2'd1;
            end
            2'd1: begin
              asm_d[15:8] = byte_in;
              phase_d     = 2'd2;
            end
            default: begin
              phase_d = 2'd0;
              if (byte_in[6:4] != 3'b000) begin
                state_d = ST_ERR;
                err_d   = ERR_FORMAT;
              end else begin
                buf_we     = 1'b1;
                inst_cnt_d = inst_cnt_q + 1'b1;
                if (byte_in[7]) begin
                  state_d = ST_RESET_CPU;
                  rc_d    = 1'b0;
                end else if (inst_cnt_q == CNT_LAST) begin
                  state_d = ST_ERR;
                  err_d   = ERR_OVERFLOW;
                end
              end
            end
          endcase
        end
      end
      ST_RESET_CPU: begin
        rc_d = 1'b1;
        if (rc_q) begin
          state_d = ST_STREAM;
          strm_d  = '0;
        end
      end
      ST_STREAM: begin
        buf_raddr = strm_q[ADDR_W-1:0] + 1'b1;
        strm_d    = strm_q + 1'b1;
        if (strm_q == inst_cnt_q - 1'b1) begin
          state_d = ST_RUN;
          tmo_d   = '0;
        end
      end
      ST_RUN: begin
        if (cpu_halted) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERR;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign byte_ready  = (state_q == ST_RECV);
  assign cpu_rst_n   = (state_q inside {ST_STREAM, ST_RUN, ST_DONE});
  assign cpu_ld_mode = (state_q != ST_STREAM);
  assign cpu_inst    = (state_q == ST_STREAM) ? buf_rdata : '0;
  assign busy        = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign done        = done_q;
  assign err         = err_q;
  assign inst_count  = inst_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios with randomized program
// contents and byte gaps, checked against a frame-level reference model.
module tb_prog_loader;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              cpu_rst_n;
  logic              cpu_ld_mode;
  logic [INST_W-1:0] cpu_inst;
  logic              cpu_halted;
  logic              busy;
  logic              done;
  logic [1:0]        err;
  logic [ADDR_W:0]   inst_count;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int rstc_cnt = 0;
  int run_cnt = 0;
  int done_cnt = 0;
  logic [INST_W-1:0] cap_q[$];
  logic [INST_W-1:0] exp_w[$];
  logic [7:0]        tx_q[$];
  bit                ok;
  logic [INST_W-1:0] w1;

  prog_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .cpu_rst_n   (cpu_rst_n),
    .cpu_ld_mode (cpu_ld_mode),
    .cpu_inst    (cpu_inst),
    .cpu_halted  (cpu_halted),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .inst_count  (inst_count)
  );

  always #5 clk = ~clk;

  // Observe the CPU-side interface once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (byte_valid && byte_ready) acc_cnt++;
    if (!cpu_ld_mode) cap_q.push_back(cpu_inst);
    if (busy && !byte_ready && !cpu_rst_n) rstc_cnt++;
    if (busy && cpu_rst_n && cpu_ld_mode) run_cnt++;
    if (done) done_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " byte_ready"},  32'(byte_ready),  32'd0);
    check({tag, " cpu_rst_n"},   32'(cpu_rst_n),   32'd0);
    check({tag, " cpu_ld_mode"}, 32'(cpu_ld_mode), 32'd1);
    check({tag, " cpu_inst"},    32'(cpu_inst),    32'd0);
    check({tag, " busy"},        32'(busy),        32'd0);
    check({tag, " done"},        32'(done),        32'd0);
    check({tag, " err"},         32'(err),         32'd0);
    check({tag, " inst_count"},  32'(inst_count),  32'd0);
  endtask

  task automatic push_word(input logic [INST_W-1:0] w, input bit last);
    tx_q.push_back(w[7:0]);
    tx_q.push_back(w[15:8]);
    tx_q.push_back({last, 3'b000, w[19:16]});
  endtask

  task automatic make_prog(input int n, input bit last_end, input bit halt_end);
    logic [INST_W-1:0] w;
    tx_q.delete();
    for (int i = 0; i < n; i++) begin
      w = INST_W'($urandom);
      if (w[19:18] == 2'b11) w[19:18] = 2'b00;
      if (halt_end && i == n - 1) w = 20'hC0000;
      push_word(w, last_end && (i == n - 1));
    end
  endtask

  // Reference model: walk the byte stream in 3-byte frames and decide the outcome.
  task automatic model(output int e_err, output int e_cnt, output int e_acc);
    logic [7:0] b0, b1, b2;
    exp_w.delete();
    e_err = 0;
    e_cnt = 0;
    e_acc = 0;
    for (int i = 0; i + 2 < tx_q.size(); i += 3) begin
      b0 = tx_q[i];
      b1 = tx_q[i + 1];
      b2 = tx_q[i + 2];
      e_acc += 3;
      if (b2[6:4] != 3'b000) begin
        e_err = 1;
        return;
      end
      exp_w.push_back({b2[3:0], b1, b0});
      e_cnt++;
      if (b2[7]) return;
      if (e_cnt == DEPTH) begin
        e_err = 2;
        return;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit acc);
    acc = 1'b0;
    repeat ($urandom_range(gap, 0)) step();
    byte_in    = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 8 && !acc; t++) begin
      if (byte_ready) acc = 1'b1;
      step();
    end
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic run_case(input string tag, input int gap, input int halt_delay);
    int e_err, e_cnt, e_acc, f_err;
    int acc0, cap0, rc0, run0, done0, t;
    bit a;
    logic [INST_W-1:0] got;
    model(e_err, e_cnt, e_acc);
    f_err = (e_err == 0 && halt_delay < 0) ? 3 : e_err;
    acc0  = acc_cnt;
    cap0  = cap_q.size();
    rc0   = rstc_cnt;
    run0  = run_cnt;
    done0 = done_cnt;

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);

    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i], gap, a);
      if (!a) break;
      if (i == e_acc - 2) check({tag, " err_before_final_byte"}, 32'(err), 32'd0);
    end

    if (e_err == 0) begin
      t = 0;
      while (!(busy && cpu_rst_n && cpu_ld_mode) && t < 300) begin
        step();
        t++;
      end
      check({tag, " reach_run"}, 32'(busy && cpu_rst_n && cpu_ld_mode), 32'd1);
      if (halt_delay >= 0) begin
        repeat (halt_delay) step();
        cpu_halted = 1'b1;
        step();
        cpu_halted = 1'b0;
        check({tag, " done_pulse"}, 32'(done), 32'd1);
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        step();
        check({tag, " done_low_after"}, 32'(done), 32'd0);
        check({tag, " cpu_running"}, 32'(cpu_rst_n), 32'd1);
      end else begin
        t = 0;
        while (err == 2'd0 && t < 1200) begin
          step();
          t++;
        end
        check({tag, " run_cycles"}, 32'(run_cnt - run0), 32'(RUN_TIMEOUT));
        check({tag, " cpu_held_rst"}, 32'(cpu_rst_n), 32'd0);
      end
    end else begin
      check({tag, " byte_ready_err"}, 32'(byte_ready), 32'd0);
      check({tag, " cpu_rst_n_err"},  32'(cpu_rst_n),  32'd0);
      check({tag, " busy_err"},       32'(busy),       32'd0);
    end

    check({tag, " err"},         32'(err),              32'(f_err));
    check({tag, " inst_count"},  32'(inst_count),       32'(e_cnt));
    check({tag, " bytes_taken"}, 32'(acc_cnt - acc0),   32'(e_acc));
    check({tag, " stream_len"},  32'(cap_q.size() - cap0), (e_err == 0) ? 32'(e_cnt) : 32'd0);
    check({tag, " rst_cycles"},  32'(rstc_cnt - rc0),   (e_err == 0) ? 32'd2 : 32'd0);
    check({tag, " done_count"},  32'(done_cnt - done0), (e_err == 0 && halt_delay >= 0) ? 32'd1 : 32'd0);
    if (e_err == 0) begin
      for (int i = 0; i < exp_w.size(); i++) begin
        got = (cap0 + i < cap_q.size()) ? cap_q[cap0 + i] : 'x;
        check($sformatf("%s word%0d", tag, i), 32'(got), 32'(exp_w[i]));
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    cpu_halted = 1'b0;
    repeat (3) step();
    check_reset_vals("reset");
    rst = 1'b0;
    step();
    $display("step: reset values checked");

    tx_q.delete();
    push_word({OP_ADD, 6'd1, 6'd2, 6'd3}, 1'b0);
    push_word({OP_MUL, 6'd4, 6'd5, 6'd6}, 1'b0);
    push_word(20'hC0000, 1'b1);
    run_case("prog3", 0, 4);
    $display("step: 3-instruction program");

    tx_q.delete();
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    tx_q.push_back(8'h30);
    tx_q.push_back(8'h44);
    run_case("format", 0, 0);
    $display("step: format error frame");

    make_prog(DEPTH, 1'b0, 1'b0);
    run_case("overflow", 0, 0);
    $display("step: 32 words without last flag");

    make_prog(DEPTH, 1'b1, 1'b1);
    run_case("full32", 1, 3);
    $display("step: 32 words with last on final word");

    make_prog(4, 1'b1, 1'b0);
    run_case("timeout", 0, -1);
    $display("step: run timeout");

    make_prog(6, 1'b1, 1'b1);
    run_case("gap0", 0, 2);
    run_case("gap3", 3, 2);
    $display("step: same program with and without byte gaps");

    make_prog(4, 1'b1, 1'b1);
    w1 = {tx_q[5][3:0], tx_q[4], tx_q[3]};
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1, ok);
    for (int t = 0; t < 20 && cpu_ld_mode; t++) step();
    check("midstream k0_ld_mode", 32'(cpu_ld_mode), 32'd0);
    step();
    check("midstream k1_inst", 32'(cpu_inst), 32'(w1));
    rst = 1'b1;
    step();
    check_reset_vals("midstream_rst");
    rst = 1'b0;
    step();
    make_prog(5, 1'b1, 1'b1);
    run_case("after_rst", 2, 1);
    $display("step: reset during stream then reload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
